// File: rtl/prod_ram_reader.sv
// Read-side controller for the product RAM: sweeps an address window and streams
// the words through a small FIFO. Define PROD_RAM_READER_CHECKSUM_EN for a stream checksum.
module prod_ram_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_op_en,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef PROD_RAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  REM_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                inflight_q, last_inflight_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    occupancy;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q;
  logic                issue, push, pop;

  // The in-flight read already owns a FIFO slot, so it counts against the depth.
  assign occupancy = count_q + CNT_W'(inflight_q);
  assign push      = inflight_q;
  assign m_valid   = (count_q != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last    = m_valid && last_q[rd_ptr_q];

  assign ram_addr  = addr_q;
  assign ram_cs    = issue;
  assign ram_op_en = issue;
  assign ram_w_en  = 1'b0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = len;
          state_d = (len != '0) ? READ : FIN;
        end
      end
      READ: begin
        busy = 1'b1;
        if ((rem_q != '0) && (occupancy < DEPTH_C)) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once the only remaining word (if any) is being accepted now.
        if (!inflight_q && (count_q == CNT_W'(pop))) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      last_inflight_q <= issue && (rem_q == REM_ONE);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage is never reset; m_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= ram_data;
      last_q[wr_ptr_q] <= last_inflight_q;
    end
  end

`ifdef PROD_RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + m_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
